// File: rtl/pipelined_addsub_if.sv
// Handshake and data bundle for pipelined_addsub.
// The master modport is the operand producer and result consumer; the slave modport is the adder.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, c, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, c, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor.
// Each stage ripples one CW-bit chunk and hands its carry to the next stage.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_addsub_if.slave    bus
);
  localparam int CW = WIDTH / STAGES;

  logic adv;

  logic [WIDTH-1:0] res_reg   [STAGES];
  logic [WIDTH-1:0] a_reg     [STAGES];
  logic [WIDTH-1:0] b_reg     [STAGES];
  logic             carry_reg [STAGES];
  logic             vld_reg   [STAGES];
  logic             ovf_reg;

  logic [WIDTH-1:0] res_next   [STAGES];
  logic [WIDTH-1:0] a_next     [STAGES];
  logic [WIDTH-1:0] b_next     [STAGES];
  logic             carry_next [STAGES];
  logic             vld_next   [STAGES];
  logic             ovf_next;

  // The whole pipeline moves as one unit whenever the output slot is free or being drained.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // Bits at or below the top of this stage's chunk are consumed here.
      localparam logic [WIDTH-1:0] DONE_MASK = {WIDTH{1'b1}} >> (WIDTH - (gi + 1) * CW);

      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] r_src;
      logic             cin_src;
      logic             v_src;
      logic [CW:0]      chunk_sum;
      logic [WIDTH-1:0] r_merged;

      if (gi == 0) begin : g_first
        // Subtraction is a + ~b + ~c, i.e. a - b - c.
        assign a_src   = bus.a;
        assign b_src   = bus.sub ? ~bus.b : bus.b;
        assign cin_src = bus.sub ? ~bus.c : bus.c;
        assign r_src   = '0;
        assign v_src   = bus.in_valid;
      end else begin : g_chain
        assign a_src   = a_reg[gi-1];
        assign b_src   = b_reg[gi-1];
        assign cin_src = carry_reg[gi-1];
        assign r_src   = res_reg[gi-1];
        assign v_src   = vld_reg[gi-1];
      end

      assign chunk_sum = {1'b0, a_src[gi*CW +: CW]}
                       + {1'b0, b_src[gi*CW +: CW]}
                       + {{CW{1'b0}}, cin_src};

      always_comb begin
        r_merged                = r_src;
        r_merged[gi*CW +: CW]   = chunk_sum[CW-1:0];
      end

      assign res_next[gi]   = r_merged;
      assign a_next[gi]     = a_src & ~DONE_MASK;
      assign b_next[gi]     = b_src & ~DONE_MASK;
      assign carry_next[gi] = chunk_sum[CW];
      assign vld_next[gi]   = v_src;

      if (gi == STAGES - 1) begin : g_last
        // Carry into the MSB is a^b^s at that bit, so ovf = that XOR carry out.
        assign ovf_next = a_src[WIDTH-1] ^ b_src[WIDTH-1]
                        ^ chunk_sum[CW-1] ^ chunk_sum[CW];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        res_reg[k]   <= '0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
        carry_reg[k] <= 1'b0;
        vld_reg[k]   <= 1'b0;
      end
      ovf_reg <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        res_reg[k]   <= res_next[k];
        a_reg[k]     <= a_next[k];
        b_reg[k]     <= b_next[k];
        carry_reg[k] <= carry_next[k];
        vld_reg[k]   <= vld_next[k];
      end
      ovf_reg <= ovf_next;
    end
  end

  assign bus.s         = res_reg[STAGES-1];
  assign bus.co        = carry_reg[STAGES-1];
  assign bus.ovf       = ovf_reg;
  assign bus.out_valid = vld_reg[STAGES-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=16, STAGES=4) with directed vectors.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(16)) bus ();

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [17:0] sb_q [$];
  logic [17:0] exp_v;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          last_acc = 0;
  int          first_acc;
  logic        ov_hist [4096];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: one line per completed output transfer.
  always @(negedge clk) begin
    if (cyc < 4096) ov_hist[cyc] = bus.out_valid;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got s=%h expected no result", bus.s);
      end else begin
        exp_v = sb_q.pop_front();
        $display("out: s=%h co=%b ovf=%b (expect s=%h co=%b ovf=%b)",
                 bus.s, bus.co, bus.ovf, exp_v[15:0], exp_v[17], exp_v[16]);
        chk("result", {14'd0, bus.co, bus.ovf, bus.s}, {14'd0, exp_v});
      end
    end
  end

  // Presents one operand set until accepted; expv is {co, ovf, s}.
  task automatic put(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                     input logic ts, input logic [17:0] expv);
    logic ok;
    ok = 1'b0;
    bus.a = ta; bus.b = tb_v; bus.c = tc; bus.sub = ts; bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        sb_q.push_back(expv);
        last_acc = cyc + 1;
        $display("in:  a=%h b=%h c=%b sub=%b", ta, tb_v, tc, ts);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  task automatic check_latency();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("latency_out_valid", {31'd0, bus.out_valid}, {31'd0, j == 3});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 0);
    chk("reset_outputs", {14'd0, bus.co, bus.ovf, bus.s}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("in_ready_after_reset", {31'd0, bus.in_ready}, 1);

    // Basic add with exact latency and one-cycle valid
    put(16'h0001, 16'h0002, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0003});
    check_latency();

    // Carry ripple, subtract, signed overflow
    put(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    put(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 1'b0, 16'hFFFF});
    put(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    put(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    put(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    drain();

    // Backpressure: hold out_ready low for 3 cycles once the first result shows
    fork
      begin
        for (int i = 1; i <= 6; i++) put(16'(i), 16'(i), 1'b0, 1'b0, {2'b00, 16'(2 * i)});
      end
      begin
        int w;
        w = 0;
        while (!bus.out_valid && w < 50) begin
          @(posedge clk); #1;
          w++;
        end
        chk("bp_first_valid", {31'd0, bus.out_valid}, 1);
        bus.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("bp_in_ready", {31'd0, bus.in_ready}, 0);
          chk("bp_s_held", {16'd0, bus.s}, 32'h0002);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Bubbles: alternate valid / idle for 8 cycles
    first_acc = 0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        put(16'(16'h1000 + k), 16'h0100, 1'b0, 1'b0, {2'b00, 16'(16'h1100 + k)});
        if (k == 0) first_acc = last_acc;
      end else begin
        @(posedge clk); #1;
      end
    end
    drain();
    for (int k = 0; k < 8; k++)
      chk("bubble_pattern", {31'd0, ov_hist[first_acc + 3 + k]}, {31'd0, k % 2 == 0});

    // Reset mid-operation with 3 sets in flight
    put(16'h0010, 16'h0020, 1'b0, 1'b0, {2'b00, 16'h0030});
    put(16'h0100, 16'h0200, 1'b0, 1'b0, {2'b00, 16'h0300});
    put(16'h1000, 16'h2000, 1'b0, 1'b0, {2'b00, 16'h3000});
    @(posedge clk); #1;
    chk("pre_reset_valid", {31'd0, bus.out_valid}, 1);
    chk("pre_reset_s", {16'd0, bus.s}, 32'h0030);
    #1 rst = 1'b1;
    sb_q.delete();
    #1;
    chk("async_reset_out_valid", {31'd0, bus.out_valid}, 0);
    chk("async_reset_outputs", {14'd0, bus.co, bus.ovf, bus.s}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("in_ready_after_rst2", {31'd0, bus.in_ready}, 1);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("no_stale_valid", {31'd0, bus.out_valid}, 0);
    end
    @(posedge clk); #1;
    put(16'h1234, 16'h1111, 1'b0, 1'b0, {2'b00, 16'h2345});
    check_latency();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
